tap_window_ctrl: RTL and testbench

- Sequences an 8-bit pixel stream into the 19-stage tap delay chain of the filtering datapath.
- Accepts pixels over a valid/ready handshake and drives the chain's input and shift enable.
- Tracks in-line column position and flags cycles where the 20-sample window holds pixels of one line only.
- At end of line, flushes the chain with zeros so consecutive lines never mix.

---
 rtl/tap_ctrl_pkg.sv | 20 ++
 rtl/tap_window_ctrl.sv | 134 +++++++++++++
 tb/tb_tap_window_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_ctrl_pkg.sv
// Shared types and defaults for the tap window controller that feeds the
// filter's pixel delay chain.
package tap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int TAPS_DEF   = 20;
    localparam int LINE_W_DEF = 640;
    localparam int DATA_W_DEF = 8;

    function automatic int col_w(input int line_w);
        return $clog2(line_w);
    endfunction

endpackage

// File: rtl/tap_window_ctrl.sv
// Sequences a pixel stream into the external tap delay chain, tags full
// single-line windows and flushes the chain with zeros at end of line.
module tap_window_ctrl
    import tap_ctrl_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_sol,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         tap_data,
    output logic                      shift_en,
    output logic                      win_valid,
    output logic [col_w(LINE_W)-1:0]  win_col,
    output logic                      line_done,
    output logic                      line_err
);

    localparam int COL_W   = col_w(LINE_W);
    localparam int FLUSH_W = $clog2(TAPS);

    localparam logic [COL_W-1:0]   FILL_LAST  = COL_W'(TAPS - 1);
    localparam logic [COL_W-1:0]   LINE_LAST  = COL_W'(LINE_W - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(TAPS - 2);

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [FLUSH_W-1:0]  flush_q, flush_d;
    logic [DATA_W-1:0]   tap_data_q, tap_data_d;
    logic                shift_en_q, shift_en_d;
    logic                win_valid_q, win_valid_d;
    logic [COL_W-1:0]    win_col_q, win_col_d;
    logic                line_done_q, line_done_d;
    logic                line_err_q, line_err_d;

    logic                accept;
    logic                sol_restart;
    logic [COL_W-1:0]    k;

    // Reset and the flush both close the input so no pixel is lost.
    always_comb begin
        in_ready = !rst && out_ready && (state_q != FLUSH);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        flush_d     = flush_q;
        tap_data_d  = tap_data_q;
        shift_en_d  = 1'b0;
        win_valid_d = 1'b0;
        win_col_d   = win_col_q;
        line_done_d = 1'b0;
        line_err_d  = 1'b0;

        // A start-of-line tag mid-line restarts counting; older chain
        // contents are hidden because the window has to refill first.
        sol_restart = in_sol && (col_q != '0);
        k           = sol_restart ? '0 : col_q;

        case (state_q)
            FLUSH: begin
                if (out_ready) begin
                    tap_data_d = '0;
                    shift_en_d = 1'b1;
                    flush_d    = flush_q + FLUSH_W'(1);
                    if (flush_q == FLUSH_LAST) begin
                        line_done_d = 1'b1;
                        state_d     = IDLE;
                        col_d       = '0;
                        flush_d     = '0;
                    end
                end
            end
            default: begin
                if (accept) begin
                    tap_data_d = in_data;
                    shift_en_d = 1'b1;
                    line_err_d = sol_restart;
                    if (k >= FILL_LAST) begin
                        win_valid_d = 1'b1;
                        win_col_d   = k - FILL_LAST;
                    end
                    if (k == LINE_LAST) begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end else begin
                        col_d   = k + COL_W'(1);
                        state_d = (k >= FILL_LAST) ? RUN : FILL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            flush_q     <= '0;
            tap_data_q  <= '0;
            shift_en_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            line_done_q <= 1'b0;
            line_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            flush_q     <= flush_d;
            tap_data_q  <= tap_data_d;
            shift_en_q  <= shift_en_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            line_done_q <= line_done_d;
            line_err_q  <= line_err_d;
        end
    end

    assign tap_data  = tap_data_q;
    assign shift_en  = shift_en_q;
    assign win_valid = win_valid_q;
    assign win_col   = win_col_q;
    assign line_done = line_done_q;
    assign line_err  = line_err_q;

endmodule

// File: tb/tb_tap_window_ctrl.sv
// Bench for tap_window_ctrl with TAPS=20, LINE_W=32: a pixel-count model of
// the line/flush rules checked every cycle, plus literal per-scenario figures.
module tb_tap_window_ctrl;

    localparam int TAPS   = 20;
    localparam int LINE_W = 32;
    localparam int DATA_W = 8;
    localparam int COL_W  = $clog2(LINE_W);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_sol;
    logic              in_ready;
    logic              out_ready;
    logic [DATA_W-1:0] tap_data;
    logic              shift_en;
    logic              win_valid;
    logic [COL_W-1:0]  win_col;
    logic              line_done;
    logic              line_err;

    tap_window_ctrl #(
        .TAPS   (TAPS),
        .LINE_W (LINE_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sol    (in_sol),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .tap_data  (tap_data),
        .shift_en  (shift_en),
        .win_valid (win_valid),
        .win_col   (win_col),
        .line_done (line_done),
        .line_err  (line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: pixels taken so far in the line and zero shifts still owed.
    int   m_pos        = 0;
    int   m_flush_left = 0;
    int   m_tap        = 0;
    int   m_wcol       = 0;
    int   m_idx;
    logic m_shift = 1'b0;
    logic m_wv    = 1'b0;
    logic m_done  = 1'b0;
    logic m_err   = 1'b0;

    always @(posedge clk) begin
        cyc     = cyc + 1;
        m_shift = 1'b0;
        m_wv    = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (rst) begin
            m_pos        = 0;
            m_flush_left = 0;
            m_tap        = 0;
            m_wcol       = 0;
        end else if (m_flush_left > 0) begin
            if (out_ready) begin
                m_shift      = 1'b1;
                m_tap        = 0;
                m_flush_left = m_flush_left - 1;
                m_done       = (m_flush_left == 0);
            end
        end else if (in_valid && out_ready) begin
            m_idx = m_pos;
            if (in_sol && m_pos != 0) begin
                m_err = 1'b1;
                m_idx = 0;
            end
            m_shift = 1'b1;
            m_tap   = int'(in_data);
            if (m_idx >= TAPS - 1) begin
                m_wv   = 1'b1;
                m_wcol = m_idx - (TAPS - 1);
            end
            if (m_idx == LINE_W - 1) begin
                m_flush_left = TAPS - 1;
                m_pos        = 0;
            end else begin
                m_pos = m_idx + 1;
            end
        end
    end

    // Per-scenario observations gathered on the falling edge.
    int acc_cyc[$];
    int win_cnt, first_win_data, first_win_col, first_win_cyc;
    int last_win_data, last_win_col, zero_shifts, busy_cycles;
    int done_cnt, first_done_cyc, done_cyc, err_cnt, err_cyc;

    task automatic clearStats();
        acc_cyc.delete();
        win_cnt = 0; first_win_data = -1; first_win_col = -1; first_win_cyc = -1;
        last_win_data = -1; last_win_col = -1; zero_shifts = 0; busy_cycles = 0;
        done_cnt = 0; first_done_cyc = -1; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic compareCycle();
        checkOutput("in_ready", 32'(in_ready), 32'(!rst && out_ready && m_flush_left == 0));
        checkOutput("shift_en", 32'(shift_en), 32'(m_shift));
        if (m_shift) checkOutput("tap_data", 32'(tap_data), m_tap);
        checkOutput("win_valid", 32'(win_valid), 32'(m_wv));
        if (m_wv) checkOutput("win_col", 32'(win_col), m_wcol);
        checkOutput("line_done", 32'(line_done), 32'(m_done));
        checkOutput("line_err", 32'(line_err), 32'(m_err));

        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (shift_en && win_valid) begin
            if (win_cnt == 0) begin
                first_win_data = int'(tap_data);
                first_win_col  = int'(win_col);
                first_win_cyc  = cyc;
            end
            last_win_data = int'(tap_data);
            last_win_col  = int'(win_col);
            win_cnt       = win_cnt + 1;
        end
        if (shift_en && tap_data == '0) zero_shifts = zero_shifts + 1;
        if (out_ready && !rst && !in_ready) busy_cycles = busy_cycles + 1;
        if (line_done) begin
            if (done_cnt == 0) first_done_cyc = cyc;
            done_cyc = cyc;
            done_cnt = done_cnt + 1;
        end
        if (line_err) begin
            err_cyc = cyc;
            err_cnt = err_cnt + 1;
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, end at next posedge+1.
    task automatic applyStimulus(input logic r, input logic v, input int d,
                                 input logic sol, input logic ordy);
        rst       = r;
        in_valid  = v;
        in_data   = DATA_W'(d);
        in_sol    = sol;
        out_ready = ordy;
        @(negedge clk);
        compareCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendPixels(input int first, input int count, input logic sol_first);
        for (int i = 0; i < count; i++)
            applyStimulus(1'b0, 1'b1, first + i, sol_first && (i == 0), 1'b1);
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (done_cnt < target && n < 80) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
            n++;
        end
        checkOutput("line_done_count", done_cnt, target);
    endtask

    // Pixels 1..32: windows carry pixels 20..32 at columns 0..12.
    task automatic checkFullLine(input string tag, input int done_latency);
        checkOutput({tag, "_win_cnt"}, win_cnt, 13);
        checkOutput({tag, "_first_win_data"}, first_win_data, 20);
        checkOutput({tag, "_first_win_col"}, first_win_col, 0);
        checkOutput({tag, "_last_win_data"}, last_win_data, 32);
        checkOutput({tag, "_last_win_col"}, last_win_col, 12);
        checkOutput({tag, "_zero_shifts"}, zero_shifts, TAPS - 1);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, TAPS - 1);
        checkOutput({tag, "_accepts"}, acc_cyc.size(), LINE_W);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
        if (acc_cyc.size() > 0)
            checkOutput({tag, "_done_latency"}, done_cyc - acc_cyc[acc_cyc.size() - 1], done_latency);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearStats();

        $display("[TB] reset with source valid");
        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_shift_en", 32'(shift_en), 0);
        checkOutput("rst_tap_data", 32'(tap_data), 0);
        checkOutput("rst_win_valid", 32'(win_valid), 0);
        checkOutput("rst_win_col", 32'(win_col), 0);
        checkOutput("rst_line_done", 32'(line_done), 0);
        checkOutput("rst_line_err", 32'(line_err), 0);
        checkOutput("rst_accepts", acc_cyc.size(), 0);

        $display("[TB] full line");
        clearStats();
        sendPixels(1, LINE_W, 1'b1);
        waitDone(1);
        // Last accept, 19 flush shifts, then the registered pulse.
        checkFullLine("full", TAPS);

        $display("[TB] backpressure");
        clearStats();
        for (int i = 0; i < LINE_W; i++) begin
            if (i == 25)
                for (int s = 0; s < 3; s++) applyStimulus(1'b0, 1'b1, i + 1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b1, i + 1, i == 0, 1'b1);
        end
        for (int s = 0; s < 5; s++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int s = 0; s < 2; s++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        waitDone(1);
        checkFullLine("bp", TAPS + 2);

        $display("[TB] premature start of line");
        clearStats();
        sendPixels(101, 10, 1'b1);
        sendPixels(111, LINE_W, 1'b1);
        waitDone(1);
        checkOutput("sol_err_cnt", err_cnt, 1);
        if (acc_cyc.size() > 10)
            checkOutput("sol_err_latency", err_cyc - acc_cyc[10], 1);
        checkOutput("sol_first_win_data", first_win_data, 130);
        checkOutput("sol_first_win_col", first_win_col, 0);
        checkOutput("sol_first_win_delay", first_win_cyc - err_cyc, TAPS - 1);
        checkOutput("sol_win_cnt", win_cnt, 13);
        checkOutput("sol_last_win_data", last_win_data, 142);

        $display("[TB] reset mid-line");
        clearStats();
        sendPixels(1, 15, 1'b1);
        applyStimulus(1'b1, 1'b1, 16, 1'b0, 1'b1);
        checkOutput("midrst_shift_en", 32'(shift_en), 0);
        checkOutput("midrst_tap_data", 32'(tap_data), 0);
        checkOutput("midrst_win_valid", 32'(win_valid), 0);
        checkOutput("midrst_line_done", 32'(line_done), 0);
        checkOutput("midrst_line_err", 32'(line_err), 0);
        for (int s = 0; s < TAPS + 5; s++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("midrst_no_done", done_cnt, 0);
        checkOutput("midrst_no_zero_shifts", zero_shifts, 0);
        clearStats();
        sendPixels(1, LINE_W, 1'b1);
        waitDone(1);
        checkFullLine("after_rst", TAPS);

        $display("[TB] back-to-back lines");
        clearStats();
        sendPixels(1, LINE_W, 1'b1);
        for (int s = 0; s < TAPS - 1; s++) applyStimulus(1'b0, 1'b1, 33, 1'b1, 1'b1);
        sendPixels(33, LINE_W, 1'b1);
        waitDone(2);
        checkOutput("b2b_accepts", acc_cyc.size(), 2 * LINE_W);
        checkOutput("b2b_win_cnt", win_cnt, 26);
        checkOutput("b2b_last_win_data", last_win_data, 64);
        checkOutput("b2b_err_cnt", err_cnt, 0);
        // The registered line_done is visible in the same clock as the next
        // line's first accept, one clock after the final flush shift issued.
        if (acc_cyc.size() > LINE_W) begin
            checkOutput("b2b_next_accept", acc_cyc[LINE_W], first_done_cyc);
            checkOutput("b2b_span", done_cyc - acc_cyc[0], 2 * (LINE_W + TAPS - 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
